// File: rtl/instr_fetch.sv
// Instruction fetch/issue stage feeding the datapath processor from a sync-read ROM.
// Latency: run pulses 2 cycles after FETCH entry (3 for mvi, which pulls an immediate word).
// Backpressure: after each run pulse the stage holds in WAIT_DONE until the processor raises done.
module instr_fetch #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [8:0]        ir,
  output logic [15:0]       din,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       icount
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_IMM   = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q,  state_d;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [8:0]        ir_q,     ir_d;
  logic [15:0]       din_q,    din_d;
  logic [15:0]       icount_q, icount_d;

  // Next-state and datapath updates; pc advances once per ROM word consumed.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    din_d    = din_q;
    icount_d = icount_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // ROM samples pc on this edge; pc moves on so an immediate is addressed next.
        pc_d    = pc_q + PC_ONE;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        ir_d = rom_data[8:0];
        case (rom_data[8:6])
          OP_MVI:  state_d = S_IMM;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_ISSUE;
        endcase
      end
      S_IMM: begin
        din_d   = rom_data;
        pc_d    = pc_q + PC_ONE;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_FETCH;
          if (icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
        end
      end
      S_HALT: begin
        // Restart always begins at address 0; retired count is kept.
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      din_q    <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      din_q    <= din_d;
      icount_q <= icount_d;
    end
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign din      = din_q;
  assign icount   = icount_q;
  assign run      = (state_q == S_ISSUE);
  assign halted   = (state_q == S_HALT);
  assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program scenarios plus randomized programs.
// A timeline model (cycles since fetch entry per instruction) predicts every output each cycle.
// A done responder answers run pulses after a programmable delay, optionally with noise.
module tb_instr_fetch;
  localparam int AW = 5;
  localparam int NW = 1 << AW;

  logic          clock  = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic          done   = 1'b0;
  logic [15:0]   rom_data;
  logic [AW-1:0] rom_addr;
  logic [8:0]    ir;
  logic [15:0]   din;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic [15:0]   icount;

  logic [15:0] rom [NW];

  int checks = 0;
  int errors = 0;

  // done responder controls
  bit noise  = 1'b0;
  int dly_lo = 1;
  int dly_hi = 1;
  int cnt    = 0;

  always #5 clock = ~clock;

  // synchronous-read program ROM
  always @(posedge clock) rom_data <= rom[rom_addr];

  instr_fetch #(.ADDR_W(AW)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .ir       (ir),
    .din      (din),
    .run      (run),
    .done     (done),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .icount   (icount)
  );

  // ---------------- behavioural model ----------------
  // m_ph: 0 idle, 1 executing (m_k = cycles since fetch entry), 2 awaiting done, 3 halted
  int            m_ph  = 0;
  int            m_k   = 0;
  logic [AW-1:0] m_a   = '0;
  logic          m_mvi = 1'b0;
  logic [8:0]    m_ir  = '0;
  logic [15:0]   m_din = '0;
  logic [15:0]   m_ic  = '0;
  logic [AW-1:0] m_nxt;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_ph = 0; m_k = 0; m_a = '0; m_mvi = 1'b0; m_ir = '0; m_din = '0; m_ic = '0;
    end else begin
      case (m_ph)
        0, 3: begin
          if (start) begin
            if (m_ph == 3) m_a = '0;
            m_ph = 1;
            m_k  = 0;
          end
        end
        1: begin
          if (m_k == 1) begin
            m_ir  = rom[m_a][8:0];
            m_mvi = (rom[m_a][8:6] == 3'b001);
            if (rom[m_a][8:6] == 3'b111) m_ph = 3;
          end
          if (m_ph == 1) begin
            m_nxt = AW'(m_a + 1);
            if (m_k == 2 && m_mvi) m_din = rom[m_nxt];
            if (m_k == (m_mvi ? 3 : 2)) m_ph = 2;
          end
          m_k = m_k + 1;
        end
        2: begin
          if (done) begin
            if (m_ic != 16'hFFFF) m_ic = m_ic + 16'd1;
            m_a  = AW'(m_a + (m_mvi ? 2 : 1));
            m_ph = 1;
            m_k  = 0;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [AW-1:0] e_pc;
    logic          e_run;
    e_run = (m_ph == 1) && (m_k >= 2) && (m_k == (m_mvi ? 3 : 2));
    case (m_ph)
      1:       e_pc = (m_k == 0) ? m_a : ((m_k >= 3) ? AW'(m_a + 2) : AW'(m_a + 1));
      2:       e_pc = AW'(m_a + (m_mvi ? 2 : 1));
      3:       e_pc = AW'(m_a + 1);
      default: e_pc = m_a;
    endcase
    chk("m_pc",       32'(pc),       32'(e_pc));
    chk("m_rom_addr", 32'(rom_addr), 32'(e_pc));
    chk("m_run",      32'(run),      32'(e_run));
    chk("m_busy",     32'(busy),     32'((m_ph == 1) || (m_ph == 2)));
    chk("m_halted",   32'(halted),   32'(m_ph == 3));
    chk("m_ir",       32'(ir),       32'(m_ir));
    chk("m_din",      32'(din),      32'(m_din));
    chk("m_icount",   32'(icount),   32'(m_ic));
  endtask

  // One clock: drive done just after the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (run) begin
      done = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
      cnt  = $urandom_range(dly_lo, dly_hi);
    end else if (cnt > 0) begin
      cnt  = cnt - 1;
      done = (cnt == 0);
    end else begin
      done = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
    @(negedge clock);
    compare_all();
  endtask

  task automatic wait_run(input int budget, output int n);
    n = 0;
    while (run !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("run_seen", 32'(run), 32'd1);
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("halt_seen", 32'(halted), 32'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cnt    = 0;
    done   = 1'b0;
    start  = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int  n;
    int  runs;
    bit  ok;
    bit  found;
    logic [8:0]  ir_s;
    logic [15:0] din_s;

    for (int i = 0; i < NW; i++) rom[i] = 16'h0000;

    // reset state
    tick();
    tick();
    chk("rst_pc",     32'(pc),     32'd0);
    chk("rst_ir",     32'(ir),     32'd0);
    chk("rst_din",    32'(din),    32'd0);
    chk("rst_run",    32'(run),    32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_icount", 32'(icount), 32'd0);
    resetn = 1'b1;
    tick();

    // mv then halt, done two cycles after run
    rom[0] = 16'h0010; rom[1] = 16'h01C0;
    dly_lo = 2; dly_hi = 2;
    kick();
    chk("s1_fetch_busy", 32'(busy), 32'd1);
    chk("s1_fetch_pc",   32'(pc),   32'd0);
    wait_run(10, n);
    chk("s1_latency", 32'(n),  32'd2);
    chk("s1_ir",      32'(ir), 32'h010);
    tick();
    chk("s1_run_once", 32'(run), 32'd0);
    tick();
    tick();
    chk("s1_icount",   32'(icount), 32'd1);
    chk("s1_next_pc",  32'(pc),     32'd1);
    wait_halt(20);
    chk("s1_halt_pc",  32'(pc),     32'd2);

    // mvi with immediate
    do_reset();
    rom[0] = 16'h0040; rom[1] = 16'h1234; rom[2] = 16'h01C0;
    kick();
    wait_run(10, n);
    chk("s2_latency", 32'(n),   32'd3);
    chk("s2_din",     32'(din), 32'h1234);
    chk("s2_ir",      32'(ir),  32'h040);
    chk("s2_pc",      32'(pc),  32'd2);
    wait_halt(20);
    chk("s2_halt_pc", 32'(pc),     32'd3);
    chk("s2_icount",  32'(icount), 32'd1);

    // add, sub, halt with done three cycles after each run
    do_reset();
    rom[0] = 16'h0080; rom[1] = 16'h00C0; rom[2] = 16'h01C0;
    dly_lo = 3; dly_hi = 3;
    kick();
    runs = 0;
    for (int i = 0; i < 60 && halted !== 1'b1; i++) begin
      tick();
      if (run === 1'b1) runs++;
    end
    chk("s3_runs",   32'(runs),   32'd2);
    chk("s3_halted", 32'(halted), 32'd1);
    chk("s3_pc",     32'(pc),     32'd3);
    chk("s3_icount", 32'(icount), 32'd2);
    kick();
    chk("s3_restart_pc",   32'(pc),     32'd0);
    chk("s3_restart_busy", 32'(busy),   32'd1);
    chk("s3_keep_icount",  32'(icount), 32'd2);

    // done withheld for 20 cycles after the pulse
    dly_lo = 21; dly_hi = 21;
    wait_run(10, n);
    ir_s = ir; din_s = din;
    runs = 0; ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = 1'b1;
      tick();
      if (run === 1'b1) runs++;
      if (busy !== 1'b1 || ir !== ir_s || din !== din_s) ok = 1'b0;
    end
    start = 1'b0;
    chk("s4_no_extra_run", 32'(runs), 32'd0);
    chk("s4_stable_busy",  32'(ok),   32'd1);
    dly_lo = 1; dly_hi = 3;
    wait_halt(80);

    // pc wrap with mvi at the last address
    do_reset();
    rom[0] = 16'hBEEF;
    for (int i = 1; i < NW - 1; i++) rom[i] = 16'h0010;
    rom[NW-1] = 16'h0040;
    dly_lo = 1; dly_hi = 2;
    kick();
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (run === 1'b1 && ir === 9'h040) found = 1'b1;
    end
    chk("s5_found", 32'(found), 32'd1);
    chk("s5_din",   32'(din),   32'hBEEF);
    chk("s5_pc",    32'(pc),    32'd1);
    rom[1] = 16'h01C0;
    wait_halt(40);
    chk("s5_halt_pc", 32'(pc), 32'd2);

    // reset during WAIT_DONE with done arriving together
    dly_lo = 30; dly_hi = 30;
    kick();
    wait_run(10, n);
    tick();
    @(posedge clock);
    #1;
    done   = 1'b1;
    resetn = 1'b0;
    #1;
    chk("s6_pc",     32'(pc),       32'd0);
    chk("s6_addr",   32'(rom_addr), 32'd0);
    chk("s6_ir",     32'(ir),       32'd0);
    chk("s6_din",    32'(din),      32'd0);
    chk("s6_run",    32'(run),      32'd0);
    chk("s6_busy",   32'(busy),     32'd0);
    chk("s6_halted", 32'(halted),   32'd0);
    chk("s6_icount", 32'(icount),   32'd0);
    done = 1'b0;
    cnt  = 0;
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("s6_idle_busy", 32'(busy), 32'd0);
    chk("s6_idle_pc",   32'(pc),   32'd0);

    // randomized programs, start toggling freely, noisy done
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < NW; i++) rom[i] = 16'($urandom);
      noise = 1'b1; dly_lo = 1; dly_hi = 6;
      for (int i = 0; i < 1000; i++) begin
        start = ($urandom_range(0, 3) == 0);
        tick();
      end
      noise = 1'b0;
      start = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
